// File: rtl/l2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_pkg
// Description : Shared FSM encoding, default geometry and derived-width
//               helpers for the set-associative L2 cache.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_pkg;

  // Controller states; numeric values are fixed because downstream debug
  // tooling decodes the raw state field.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARE   = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_ALLOCATE  = 2'd3
  } l2_state_e;

  // Default geometry
  localparam int c_def_ways   = 2;
  localparam int c_def_sets   = 64;
  localparam int c_def_line_w = 128;
  localparam int c_def_addr_w = 30;
  localparam int c_def_cnt_w  = 16;

  // Set-index width
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Tag width: word address minus the 2 word-in-line bits and the index
  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - 2 - $clog2(sets);
  endfunction

  // Way-number / age-field width; a direct-mapped cache still needs 1 bit
  // to declare the (unused) storage
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_lru_set.sv
`default_nettype none
// ============================================================================
// Module      : l2_lru_set
// Description : Combinational true-LRU logic for one set: age update for an
//               access to i_hit_way and victim selection (lowest invalid way,
//               otherwise the oldest way).
// Revision    : 1.0 - initial release
// ============================================================================
module l2_lru_set
  import l2_pkg::*;
#(
  parameter int WAYS  = c_def_ways,
  parameter int WAY_W = way_w(WAYS)
) (
  input  logic [WAYS*WAY_W-1:0] i_ages,
  input  logic [WAYS-1:0]       i_valid,
  input  logic [WAY_W-1:0]      i_hit_way,
  output logic [WAYS*WAY_W-1:0] o_ages,
  output logic [WAY_W-1:0]      o_victim_way
);

  logic [WAY_W-1:0] w_old_age;
  logic             w_found;

  // Accessed way becomes age 0; every way younger than its old age ages by one
  always_comb begin
    w_old_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == i_hit_way) w_old_age = i_ages[w*WAY_W +: WAY_W];
    end
    o_ages = i_ages;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == i_hit_way) begin
        o_ages[w*WAY_W +: WAY_W] = '0;
      end else if (i_ages[w*WAY_W +: WAY_W] < w_old_age) begin
        o_ages[w*WAY_W +: WAY_W] = i_ages[w*WAY_W +: WAY_W] + WAY_W'(1);
      end
    end
  end

  // Fill invalid ways first (lowest index); ages stay a permutation, so the
  // LRU way is the unique one holding age WAYS-1
  always_comb begin
    o_victim_way = '0;
    w_found      = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_found && !i_valid[w]) begin
        o_victim_way = WAY_W'(w);
        w_found      = 1'b1;
      end
    end
    if (!w_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (i_ages[w*WAY_W +: WAY_W] == WAY_W'(WAYS - 1)) o_victim_way = WAY_W'(w);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_cache_assoc.sv
`default_nettype none
// ============================================================================
// Module      : l2_cache_assoc
// Description : Write-back, write-allocate N-way set-associative L2 cache with
//               true-LRU replacement, line-granular L1 and memory handshakes,
//               and access/miss statistic counters.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_cache_assoc
  import l2_pkg::*;
#(
  parameter int WAYS   = c_def_ways,
  parameter int SETS   = c_def_sets,
  parameter int LINE_W = c_def_line_w,
  parameter int ADDR_W = c_def_addr_w,
  parameter int CNT_W  = c_def_cnt_w
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [LINE_W-1:0]   wdata,
  output logic [LINE_W-1:0]   rdata,
  output logic                ready,
  output logic                stall,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [LINE_W-1:0]   mem_wdata,
  input  logic [LINE_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic [CNT_W-1:0]    access_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);

  localparam int IDX_W   = idx_w(SETS);
  localparam int TAG_W   = tag_w(ADDR_W, SETS);
  localparam int MADDR_W = ADDR_W - 2;
  localparam int WAY_W   = way_w(WAYS);

  localparam logic [1:0] c_st_idle      = ST_IDLE;
  localparam logic [1:0] c_st_compare   = ST_COMPARE;
  localparam logic [1:0] c_st_writeback = ST_WRITEBACK;
  localparam logic [1:0] c_st_allocate  = ST_ALLOCATE;

  // Reset ordering of a set: way w has age w
  function automatic logic [WAYS*WAY_W-1:0] age_init();
    logic [WAYS*WAY_W-1:0] v;
    v = '0;
    for (int w = 0; w < WAYS; w++) v[w*WAY_W +: WAY_W] = WAY_W'(w);
    return v;
  endfunction

  localparam logic [WAYS*WAY_W-1:0] c_age_init = age_init();

  // Controller and output registers
  logic [1:0]         r_state;
  logic               r_is_write;
  logic [WAY_W-1:0]   r_victim;
  logic               r_ready;
  logic               r_stall;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [MADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0]  r_mem_wdata;
  logic [LINE_W-1:0]  r_rdata;
  logic [CNT_W-1:0]   r_access_cnt;
  logic [CNT_W-1:0]   r_miss_cnt;

  // Cache storage
  logic [TAG_W-1:0]       r_tag   [WAYS][SETS];
  logic [LINE_W-1:0]      r_data  [WAYS][SETS];
  logic [WAYS-1:0]        r_valid [SETS];
  logic [WAYS-1:0]        r_dirty [SETS];
  logic [WAYS*WAY_W-1:0]  r_age   [SETS];

  logic [IDX_W-1:0]       w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic [MADDR_W-1:0]     w_line_addr;
  logic                   w_hit;
  logic [WAY_W-1:0]       w_hit_way;
  logic [WAY_W-1:0]       w_victim_way;
  logic [WAYS*WAY_W-1:0]  w_age_next;
  logic                   w_vic_dirty;
  logic                   w_unused_addr;

  assign w_idx         = addr[IDX_W+1:2];
  assign w_tag         = addr[ADDR_W-1:IDX_W+2];
  assign w_line_addr   = addr[ADDR_W-1:2];
  assign w_unused_addr = &{1'b0, addr[1:0]};
  assign w_vic_dirty   = r_valid[w_idx][w_victim_way] & r_dirty[w_idx][w_victim_way];

  // Tag lookup across all ways of the addressed set; lowest matching way wins
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  generate
    if (WAYS > 1) begin : g_lru
      l2_lru_set #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
      ) u_lru (
        .i_ages       (r_age[w_idx]),
        .i_valid      (r_valid[w_idx]),
        .i_hit_way    (w_hit_way),
        .o_ages       (w_age_next),
        .o_victim_way (w_victim_way)
      );
    end else begin : g_direct
      assign w_age_next   = r_age[w_idx];
      assign w_victim_way = '0;
    end
  endgenerate

  // Request FSM, memory handshake and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_st_idle;
      r_is_write   <= 1'b0;
      r_victim     <= '0;
      r_ready      <= 1'b0;
      r_stall      <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rdata      <= '0;
      r_access_cnt <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        c_st_idle: begin
          if (read || write) begin
            r_state      <= c_st_compare;
            r_stall      <= 1'b1;
            r_is_write   <= write & ~read;
            r_access_cnt <= r_access_cnt + CNT_W'(1);
          end
        end
        c_st_compare: begin
          if (w_hit) begin
            r_ready <= 1'b1;
            r_stall <= 1'b0;
            if (!r_is_write) r_rdata <= r_data[w_hit_way][w_idx];
            r_state <= c_st_idle;
          end else begin
            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            r_victim   <= w_victim_way;
            if (w_vic_dirty) begin
              r_mem_write <= 1'b1;
              r_mem_addr  <= {r_tag[w_victim_way][w_idx], w_idx};
              r_mem_wdata <= r_data[w_victim_way][w_idx];
              r_state     <= c_st_writeback;
            end else begin
              r_mem_read <= 1'b1;
              r_mem_addr <= w_line_addr;
              r_state    <= c_st_allocate;
            end
          end
        end
        c_st_writeback: begin
          if (mem_ready) begin
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
            r_mem_addr  <= w_line_addr;
            r_state     <= c_st_allocate;
          end
        end
        c_st_allocate: begin
          if (mem_ready) begin
            r_mem_read <= 1'b0;
            r_state    <= c_st_compare;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // Valid/dirty/age bookkeeping; the fill itself leaves ages alone and the
  // hit in the following COMPARE makes the new line MRU
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_age[s]   <= c_age_init;
      end
    end else begin
      if ((r_state == c_st_compare) && w_hit) begin
        r_age[w_idx] <= w_age_next;
        if (r_is_write) r_dirty[w_idx][w_hit_way] <= 1'b1;
      end
      if ((r_state == c_st_allocate) && mem_ready) begin
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= 1'b0;
      end
    end
  end

  // Line data and tag storage; contents are meaningless until valid is set
  always_ff @(posedge clk) begin
    if (!reset) begin
      if ((r_state == c_st_compare) && w_hit && r_is_write) begin
        r_data[w_hit_way][w_idx] <= wdata;
      end
      if ((r_state == c_st_allocate) && mem_ready) begin
        r_data[r_victim][w_idx] <= mem_rdata;
        r_tag[r_victim][w_idx]  <= w_tag;
      end
    end
  end

  assign rdata      = r_rdata;
  assign ready      = r_ready;
  assign stall      = r_stall;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign access_cnt = r_access_cnt;
  assign miss_cnt   = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_l2_cache_assoc.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_cache_assoc
// Description : Scoreboard bench for l2_cache_assoc. A recency-list cache
//               model predicts responses, write-backs and fills; a memory
//               responder and a ready monitor check the DUT against them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_cache_assoc;
  import l2_pkg::*;

  localparam int WAYS = 2, SETS = 64, LINE_W = 128, ADDR_W = 30, CNT_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              read = 1'b0, write = 1'b0;
  logic [29:0]       addr = '0;
  logic [127:0]      wdata = '0;
  logic [127:0]      rdata;
  logic              ready, stall, mem_read, mem_write;
  logic [27:0]       mem_addr;
  logic [127:0]      mem_wdata;
  logic [127:0]      mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic [15:0]       access_cnt, miss_cnt;

  l2_cache_assoc #(.WAYS(WAYS), .SETS(SETS), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .stall(stall), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .access_cnt(access_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic is_rd; logic [127:0] rdata; int lat; logic [15:0] acc; logic [15:0] mis; } resp_t;
  typedef struct { logic [27:0] a; logic [127:0] d; } wb_t;
  resp_t        resp_q[$];
  wb_t          wb_q[$];
  logic [27:0]  fill_q[$];

  // Reference model: per set, lines ordered most- to least-recently used
  logic [21:0]  m_tag   [SETS][WAYS];
  logic         m_dirty [SETS][WAYS];
  logic [127:0] m_data  [SETS][WAYS];
  int           m_cnt   [SETS];
  logic [127:0] mem_ref [logic [27:0]];
  logic [15:0]  acc_ref = 0, miss_ref = 0;

  // Memory seen by the DUT
  logic [127:0] mem_arr [logic [27:0]];
  int lat_w = 1, lat_r = 1, req_cyc = 0;

  function automatic logic [127:0] init_line(input logic [27:0] a);
    return {4{4'h5, a}};
  endfunction

  function automatic logic [127:0] mem_get(input logic [27:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return init_line(a);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
    acc_ref = 0;
    miss_ref = 0;
  endtask

  // Predict one request and queue everything the DUT is expected to produce
  task automatic model_access(input logic rd, input logic wr, input logic [29:0] ad,
                              input logic [127:0] wd, input int lw, input int lr);
    int s, p;
    logic [21:0] t, et;
    logic [27:0] la;
    logic ed;
    logic [127:0] edat;
    resp_t r;
    wb_t e;
    s  = int'(ad[7:2]);
    t  = ad[29:8];
    la = ad[29:2];
    p  = -1;
    for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == t) p = i;
    acc_ref++;
    r.lat = 2;
    if (p < 0) begin
      miss_ref++;
      r.lat = 3 + lr;
      if (m_cnt[s] == WAYS) begin
        p = WAYS - 1;
        if (m_dirty[s][p]) begin
          e.a = {m_tag[s][p], 6'(s)};
          e.d = m_data[s][p];
          wb_q.push_back(e);
          mem_ref[e.a] = e.d;
          r.lat += lw;
        end
      end else begin
        p = m_cnt[s];
        m_cnt[s]++;
      end
      fill_q.push_back(la);
      m_tag[s][p]   = t;
      m_dirty[s][p] = 1'b0;
      m_data[s][p]  = mem_ref.exists(la) ? mem_ref[la] : init_line(la);
    end
    et = m_tag[s][p]; ed = m_dirty[s][p]; edat = m_data[s][p];
    for (int i = p; i > 0; i--) begin
      m_tag[s][i] = m_tag[s][i-1]; m_dirty[s][i] = m_dirty[s][i-1]; m_data[s][i] = m_data[s][i-1];
    end
    m_tag[s][0] = et; m_dirty[s][0] = ed; m_data[s][0] = edat;
    if (wr && !rd) begin
      m_data[s][0]  = wd;
      m_dirty[s][0] = 1'b1;
    end
    r.is_rd = rd;
    r.rdata = m_data[s][0];
    r.acc   = acc_ref;
    r.mis   = miss_ref;
    resp_q.push_back(r);
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [29:0] ad,
                        input logic [127:0] wd, input int lw, input int lr);
    int k;
    bit done;
    @(negedge clk);
    model_access(rd, wr, ad, wd, lw, lr);
    lat_w = lw; lat_r = lr; req_cyc = cyc;
    read = rd; write = wr; addr = ad; wdata = wd;
    k = 0; done = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("stall_after_accept", 128'(stall), 128'(1));
      if (ready) done = 1;
    end
    read = 0; write = 0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL req_timeout: no ready within %0d cycles, addr=%0h", k, ad);
      resp_q.delete();
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", 128'(ready), 128'(0));
    chk("rst_stall", 128'(stall), 128'(0));
    chk("rst_rdata", rdata, 128'(0));
    chk("rst_mem_read", 128'(mem_read), 128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_mem_wdata", mem_wdata, 128'(0));
    chk("rst_access_cnt", 128'(access_cnt), 128'(0));
    chk("rst_miss_cnt", 128'(miss_cnt), 128'(0));
  endtask

  // Monitor: every ready pulse is matched against the oldest predicted response
  initial begin : monitor
    resp_t r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (ready) begin
          if (resp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_ready: actual=1 required=0 (cycle %0d)", cyc);
          end else begin
            r = resp_q.pop_front();
            chk("latency", 128'(cyc - req_cyc), 128'(r.lat));
            if (r.is_rd) chk("rdata", rdata, r.rdata);
            chk("access_cnt", 128'(access_cnt), 128'(r.acc));
            chk("miss_cnt", 128'(miss_cnt), 128'(r.mis));
            chk("stall_at_ready", 128'(stall), 128'(0));
          end
        end else begin
          chk("rdata_outside_ready", rdata, 128'(0));
        end
      end
    end
  end

  // Memory responder: checks each new transaction, answers after the chosen latency
  initial begin : responder
    logic is_w;
    logic [27:0] a;
    int lat, k;
    bit ab;
    wb_t e;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = '0;
      if (!reset && (mem_write || mem_read)) begin
        is_w = mem_write;
        a    = mem_addr;
        lat  = is_w ? lat_w : lat_r;
        if (is_w) begin
          if (wb_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_mem_write: addr=%0h required=none", a);
          end else begin
            e = wb_q.pop_front();
            chk("wb_addr", 128'(a), 128'(e.a));
            chk("wb_data", mem_wdata, e.d);
          end
        end else begin
          if (fill_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_mem_read: addr=%0h required=none", a);
          end else begin
            chk("fill_addr", 128'(a), 128'(fill_q.pop_front()));
          end
        end
        k = 1; ab = 0;
        while (k < lat) begin
          @(negedge clk);
          if (!(is_w ? mem_write : mem_read)) begin
            ab = 1;
            break;
          end
          k++;
        end
        if (!ab) begin
          if (is_w) mem_arr[a] = mem_wdata;
          else mem_rdata = mem_get(a);
          mem_ready = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k, op;
    logic [29:0] ad;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs();

    // Cold miss with latency 3, then the same line hits
    do_req(1, 0, 30'h100, '0, 1, 3);
    do_req(1, 0, 30'h100, '0, 1, 3);
    // LRU in set 0: A, B, A, C -> C replaces B; A still hits, B misses
    do_req(1, 0, 30'h200, '0, 1, 2);
    do_req(1, 0, 30'h100, '0, 1, 2);
    do_req(1, 0, 30'h300, '0, 1, 1);
    do_req(1, 0, 30'h100, '0, 1, 1);
    do_req(1, 0, 30'h200, '0, 1, 2);
    // Dirty line X evicted by two conflicting reads, then read back from memory
    do_req(0, 1, 30'h404, {4{32'hDEADBEEF}}, 1, 2);
    do_req(1, 0, 30'h504, '0, 1, 2);
    do_req(1, 0, 30'h604, '0, 3, 2);
    do_req(1, 0, 30'h404, '0, 2, 4);
    // Read and write together: treated as a read, line stays clean
    do_req(1, 1, 30'h808, {4{32'hBAD0BAD0}}, 1, 1);
    do_req(1, 0, 30'h908, '0, 1, 1);
    do_req(1, 0, 30'hA08, '0, 1, 1);
    do_req(1, 0, 30'h808, '0, 1, 1);

    // Reset while ALLOCATE is waiting on memory
    ad = {22'd3, 6'd10, 2'd0};
    @(negedge clk);
    model_access(1, 0, ad, '0, 1, 8);
    lat_w = 1; lat_r = 8; req_cyc = cyc;
    read = 1; addr = ad;
    k = 0;
    while (!mem_read && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("reached_allocate", 128'(mem_read), 128'(1));
    @(negedge clk);
    reset = 1'b1;
    read  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_outputs();
    model_reset();
    resp_q.delete();
    fill_q.delete();
    wb_q.delete();
    do_req(1, 0, ad, '0, 1, 2);

    // Randomised traffic over a few sets and tags to force conflicts
    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 3));
      ad = {22'($urandom_range(0, 5)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      do_req(op != 2, op >= 2, ad, {$urandom, $urandom, $urandom, $urandom},
             int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
    end

    repeat (5) @(negedge clk);
    chk("pending_responses", 128'(resp_q.size()), 128'(0));
    chk("pending_writebacks", 128'(wb_q.size()), 128'(0));
    chk("pending_fills", 128'(fill_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
